wishbone_param_interconnect: RTL and testbench
==============================================

WISHBONE_PARAM_INTERCONNECT -- requirements
Module: wishbone_param_interconnect

Interface
REQ-001 SHALL have parameter N_SLAVES, default 4, number of slave ports (1..16).
REQ-002 SHALL have parameter SEL_MSB, default 31, top bit of slave-select field in m_adr_i.
REQ-003 SHALL have parameter SEL_LSB, default 24, bottom bit of slave-select field.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, max cycles awaiting slave ack (2..65535).
REQ-005 SHALL have parameter INT_MASK, default all ones (N_SLAVES bits), slave interrupt enable.
REQ-006 SHALL have one clock and asynchronous active-high reset: clk in 1, rst in 1.
REQ-007 SHALL have master ports: m_we_i in 1; m_cyc_i in 1; m_stb_i in 1; m_sel_i in 4; m_adr_i in 32; m_dat_i in 32; m_dat_o out 32 read data; m_ack_o out 1; m_err_o out 1 bus error; m_int_o out 1.
REQ-008 SHALL have shared slave outputs: s_we_o out 1; s_sel_o out 4; s_adr_o out 32; s_dat_o out 32.
REQ-009 SHALL have per-slave ports: s_cyc_o out N_SLAVES; s_stb_o out N_SLAVES; s_ack_i in N_SLAVES; s_int_i in N_SLAVES; s_dat_i in 32*N_SLAVES, slave i at bits [32i+31:32i].

Function
REQ-010 SHALL implement FSM states IDLE, ACTIVE, DONE, ERROR.
REQ-011 IDLE: on m_cyc_i & m_stb_i SHALL latch idx = m_adr_i[SEL_MSB:SEL_LSB], m_we_i, m_sel_i, m_dat_i, m_adr_i.
REQ-012 IDLE, idx < N_SLAVES: SHALL go ACTIVE next cycle with s_cyc_o[idx], s_stb_o[idx] high (registered, one-cycle latency); other bits low.
REQ-013 IDLE, idx >= N_SLAVES: SHALL go ERROR; no slave strobed.
REQ-014 s_adr_o SHALL carry latched address with select field zeroed; s_we_o/s_sel_o/s_dat_o latched values, stable throughout ACTIVE.
REQ-015 ACTIVE: 16-bit wait counter SHALL start at 0 and increment each cycle.
REQ-016 ACTIVE, s_ack_i[idx] high: SHALL capture s_dat_i[idx] into m_dat_o, drop s_cyc_o/s_stb_o, go DONE.
REQ-017 DONE: m_ack_o SHALL be high exactly one cycle; next state IDLE.
REQ-018 ACTIVE, counter = TIMEOUT_CYCLES-1 with no ack: SHALL drop slave strobes, go ERROR.
REQ-019 Ack and timeout in same cycle: ack SHALL win.
REQ-020 ERROR: m_err_o high exactly one cycle, m_ack_o low, m_dat_o unchanged; next IDLE.
REQ-021 ACTIVE, m_cyc_i low (abort): SHALL drop slave strobes, go IDLE next cycle, no ack/err.
REQ-022 s_ack_i on non-selected slaves SHALL be ignored.
REQ-023 Writes SHALL leave m_dat_o unchanged.
REQ-024 m_int_o SHALL be registered |(s_int_i & INT_MASK), one-cycle latency, independent of FSM.
REQ-025 Master-ack latency: slave ack at cycle k -> m_ack_o at cycle k+1; FSM accepts new request from k+2.

Reset
REQ-026 rst high SHALL asynchronously force IDLE, counter 0, m_dat_o 0, m_ack_o 0, m_err_o 0, m_int_o 0, s_cyc_o 0, s_stb_o 0, s_we_o 0, s_sel_o 0, s_adr_o 0, s_dat_o 0.
REQ-027 Reset mid-ACTIVE SHALL drop slave strobes immediately, no ack/err pulse after release.
REQ-028 First request accepted SHALL be on first rising edge after rst deasserts.

Structure
REQ-029 FSM state encoding and counter width constant SHALL reside in shared package wishbone_interconnect_pkg.
REQ-030 Wait counter with terminal-count flag SHALL be sub-module wb_ic_timeout_counter (ports clk, rst, clear, enable, expired).

Verification (N_SLAVES=4, SEL 31:24, TIMEOUT_CYCLES=16)
REQ-031 Read 0x02000010, slave 2 acks 3 cycles after strobe with 0xCAFEF00D -> s_adr_o=0x00000010, m_dat_o=0xCAFEF00D, one-cycle m_ack_o, m_err_o never high.
REQ-032 Write 0x01000004 data 0x12345678 sel 0xF, slave 1 acks -> s_dat_o=0x12345678, s_we_o=1, only s_stb_o[1] high, m_ack_o pulse.
REQ-033 Access 0x07000000 -> no s_stb_o bit high, m_err_o pulse 2 cycles after request.
REQ-034 Slave 0 never acks -> s_stb_o[0] high 16 cycles, then m_err_o one-cycle pulse, IDLE.
REQ-035 Drop m_cyc_i during ACTIVE, then rst mid-ACTIVE on second transfer -> strobes drop, no ack/err, all outputs 0.
REQ-036 s_int_i=0b1010, INT_MASK=0b0010 -> m_int_o=1 one cycle later; INT_MASK=0b0101 -> m_int_o=0.

Source files
------------

// File: rtl/wishbone_interconnect_pkg.sv
// rtl/wishbone_interconnect_pkg.sv - shared FSM encoding and counter width for the wishbone interconnect
package wishbone_interconnect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE,
    ST_ERROR
  } ic_state_t;

  localparam int WAIT_CNT_W = 16;

  // Bits [msb:lsb] set; used to clear the slave-select field from forwarded addresses.
  function automatic logic [31:0] sel_field_mask(input int msb, input int lsb);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 32; i++) begin
      mask[i] = (i >= lsb) && (i <= msb);
    end
    return mask;
  endfunction

endpackage

// File: rtl/wishbone_param_interconnect_if.sv
// rtl/wishbone_param_interconnect_if.sv - master-side and slave-side bus signals of the interconnect
interface wishbone_param_interconnect_if #(
  parameter int N_SLAVES = 4
);

  logic                    m_we_i;
  logic                    m_cyc_i;
  logic                    m_stb_i;
  logic [3:0]              m_sel_i;
  logic [31:0]             m_adr_i;
  logic [31:0]             m_dat_i;
  logic [31:0]             m_dat_o;
  logic                    m_ack_o;
  logic                    m_err_o;
  logic                    m_int_o;

  logic                    s_we_o;
  logic [3:0]              s_sel_o;
  logic [31:0]             s_adr_o;
  logic [31:0]             s_dat_o;
  logic [N_SLAVES-1:0]     s_cyc_o;
  logic [N_SLAVES-1:0]     s_stb_o;
  logic [N_SLAVES-1:0]     s_ack_i;
  logic [N_SLAVES-1:0]     s_int_i;
  logic [32*N_SLAVES-1:0]  s_dat_i;

  // Interconnect view: a slave to the master, driving the shared slave bus.
  modport slave (
    input  m_we_i, m_cyc_i, m_stb_i, m_sel_i, m_adr_i, m_dat_i,
    output m_dat_o, m_ack_o, m_err_o, m_int_o,
    output s_we_o, s_sel_o, s_adr_o, s_dat_o, s_cyc_o, s_stb_o,
    input  s_ack_i, s_int_i, s_dat_i
  );

  // Environment view: the bus master plus the attached slaves.
  modport master (
    output m_we_i, m_cyc_i, m_stb_i, m_sel_i, m_adr_i, m_dat_i,
    input  m_dat_o, m_ack_o, m_err_o, m_int_o,
    input  s_we_o, s_sel_o, s_adr_o, s_dat_o, s_cyc_o, s_stb_o,
    output s_ack_i, s_int_i, s_dat_i
  );

endinterface

// File: rtl/wb_ic_timeout_counter.sv
// rtl/wb_ic_timeout_counter.sv - wait counter with terminal-count flag for slave ack timeout
module wb_ic_timeout_counter
  import wishbone_interconnect_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WAIT_CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == WAIT_CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wishbone_param_interconnect.sv
// rtl/wishbone_param_interconnect.sv - single-master to N-slave wishbone interconnect with timeout and bus error
module wishbone_param_interconnect
  import wishbone_interconnect_pkg::*;
#(
  parameter int                  N_SLAVES       = 4,
  parameter int                  SEL_MSB        = 31,
  parameter int                  SEL_LSB        = 24,
  parameter int                  TIMEOUT_CYCLES = 16,
  parameter logic [N_SLAVES-1:0] INT_MASK       = '1
) (
  input logic                    clk,
  input logic                    rst,
  wishbone_param_interconnect_if.slave bus
);

  localparam int          SEL_W    = SEL_MSB - SEL_LSB + 1;
  localparam int          IDX_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [31:0] SEL_MASK = sel_field_mask(SEL_MSB, SEL_LSB);

  ic_state_t           state;
  logic [IDX_W-1:0]    idx;
  logic [SEL_W-1:0]    req_sel_field;
  logic                req_in_range;
  logic [N_SLAVES-1:0] req_onehot;
  logic                ack_hit;
  logic [31:0]         rdata;
  logic                timer_expired;

  assign req_sel_field = bus.m_adr_i[SEL_MSB:SEL_LSB];
  assign req_in_range  = 32'(req_sel_field) < 32'(N_SLAVES);
  assign req_onehot    = N_SLAVES'(1) << req_sel_field[IDX_W-1:0];
  assign ack_hit       = bus.s_ack_i[idx];

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (idx == IDX_W'(i)) begin
        rdata = bus.s_dat_i[32*i +: 32];
      end
    end
  end

  wb_ic_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_ACTIVE),
    .enable  (state == ST_ACTIVE),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      bus.m_dat_o <= '0;
      bus.m_ack_o <= 1'b0;
      bus.m_err_o <= 1'b0;
      bus.s_cyc_o <= '0;
      bus.s_stb_o <= '0;
      bus.s_we_o  <= 1'b0;
      bus.s_sel_o <= '0;
      bus.s_adr_o <= '0;
      bus.s_dat_o <= '0;
    end else begin
      bus.m_ack_o <= 1'b0;
      bus.m_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.m_cyc_i && bus.m_stb_i) begin
            idx         <= req_sel_field[IDX_W-1:0];
            bus.s_we_o  <= bus.m_we_i;
            bus.s_sel_o <= bus.m_sel_i;
            bus.s_dat_o <= bus.m_dat_i;
            bus.s_adr_o <= bus.m_adr_i & ~SEL_MASK;
            if (req_in_range) begin
              bus.s_cyc_o <= req_onehot;
              bus.s_stb_o <= req_onehot;
              state       <= ST_ACTIVE;
            end else begin
              state <= ST_ERROR;
            end
          end
        end
        ST_ACTIVE: begin
          // Abort beats ack, and ack beats a simultaneous timeout.
          if (!bus.m_cyc_i) begin
            bus.s_cyc_o <= '0;
            bus.s_stb_o <= '0;
            state       <= ST_IDLE;
          end else if (ack_hit) begin
            bus.s_cyc_o <= '0;
            bus.s_stb_o <= '0;
            bus.m_ack_o <= 1'b1;
            if (!bus.s_we_o) begin
              bus.m_dat_o <= rdata;
            end
            state <= ST_DONE;
          end else if (timer_expired) begin
            bus.s_cyc_o <= '0;
            bus.s_stb_o <= '0;
            state       <= ST_ERROR;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        ST_ERROR: begin
          bus.m_err_o <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_int_o <= 1'b0;
    end else begin
      bus.m_int_o <= |(bus.s_int_i & INT_MASK);
    end
  end

endmodule

// File: tb/tb_wishbone_param_interconnect.sv
// tb/tb_wishbone_param_interconnect.sv - self-checking bench for wishbone_param_interconnect
module tb_wishbone_param_interconnect;

  localparam int         N       = 4;
  localparam int         TIMEOUT = 16;
  localparam logic [3:0] MASK_A  = 4'b0010;
  localparam logic [3:0] MASK_B  = 4'b0101;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wishbone_param_interconnect_if #(.N_SLAVES(N)) bus ();
  wishbone_param_interconnect_if #(.N_SLAVES(N)) bus_b ();

  wishbone_param_interconnect #(
    .N_SLAVES(N), .SEL_MSB(31), .SEL_LSB(24), .TIMEOUT_CYCLES(TIMEOUT), .INT_MASK(MASK_A)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  wishbone_param_interconnect #(
    .N_SLAVES(N), .SEL_MSB(31), .SEL_LSB(24), .TIMEOUT_CYCLES(TIMEOUT), .INT_MASK(MASK_B)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_mdat;

  // Observations of the most recent transfer, cycle 0 being the cycle the request is presented.
  int r_ack_cycle, r_err_cycle, r_ack_count, r_err_count;
  int r_first_stb, r_stb_count, r_bad_stb, r_unstable;
  logic [31:0] r_sadr, r_sdat;
  logic        r_swe;
  logic [3:0]  r_ssel;

  typedef struct {
    int          ack_cycle;
    int          err_cycle;
    int          first_stb;
    int          stb_count;
    logic [31:0] dat_o;
  } exp_t;

  function automatic exp_t model(input logic [31:0] adr, input logic we, input int delay,
                                 input logic [31:0] rdat, input logic [31:0] prev);
    exp_t e;
    int   slave;
    slave   = int'(adr[31:24]);
    e.dat_o = prev;
    if (slave >= N) begin
      e.ack_cycle = -1; e.err_cycle = 2; e.first_stb = -1; e.stb_count = 0;
    end else if (delay < TIMEOUT) begin
      e.ack_cycle = delay + 2; e.err_cycle = -1; e.first_stb = 1; e.stb_count = delay + 1;
      if (!we) e.dat_o = rdat;
    end else begin
      e.ack_cycle = -1; e.err_cycle = TIMEOUT + 2; e.first_stb = 1; e.stb_count = TIMEOUT;
    end
    return e;
  endfunction

  task automatic drive_req(input logic [31:0] adr, input logic we, input logic [31:0] dat, input logic [3:0] sel);
    bus.m_adr_i = adr; bus.m_we_i = we; bus.m_dat_i = dat; bus.m_sel_i = sel;
    bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1;
  endtask

  // Master issues one request; the addressed slave acks once it has been strobed delay+1 cycles.
  task automatic run_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat, input logic [3:0] sel,
                          input int delay, input logic [31:0] rdat);
    int tgt;
    int done_at;
    tgt = int'(adr[31:24]);
    done_at = -1;
    r_ack_cycle = -1; r_err_cycle = -1; r_ack_count = 0; r_err_count = 0;
    r_first_stb = -1; r_stb_count = 0; r_bad_stb = 0; r_unstable = 0;
    @(posedge clk); #1;
    drive_req(adr, we, wdat, sel);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.m_ack_o) begin r_ack_count++; if (r_ack_cycle < 0) r_ack_cycle = c; end
      if (bus.m_err_o) begin r_err_count++; if (r_err_cycle < 0) r_err_cycle = c; end
      if (bus.s_stb_o != 0 || bus.s_cyc_o != 0) begin
        r_stb_count++;
        if (tgt >= N || bus.s_stb_o != (4'b0001 << tgt) || bus.s_cyc_o != bus.s_stb_o) r_bad_stb++;
        if (r_first_stb < 0) begin
          r_first_stb = c;
          r_sadr = bus.s_adr_o; r_sdat = bus.s_dat_o; r_swe = bus.s_we_o; r_ssel = bus.s_sel_o;
        end else if ({bus.s_adr_o, bus.s_dat_o, bus.s_we_o, bus.s_sel_o} !== {r_sadr, r_sdat, r_swe, r_ssel}) begin
          r_unstable++;
        end
      end
      bus.s_ack_i = 4'($urandom);
      bus.s_dat_i = {$urandom, $urandom, $urandom, $urandom};
      if (tgt < N) begin
        bus.s_ack_i[tgt] = bus.s_stb_o[tgt] && (r_stb_count == delay + 1);
        bus.s_dat_i[32*tgt +: 32] = rdat;
      end
      if ((bus.m_ack_o || bus.m_err_o) && done_at < 0) begin
        bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0; done_at = c;
      end
      if (done_at >= 0 && c >= done_at + 3) break;
    end
    bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
    bus.s_ack_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.m_ack_o, bus.m_err_o, bus.m_int_o} !== 3'b000) begin
      errors++; $display("FAIL reset_master_flags: got %b required 000", {bus.m_ack_o, bus.m_err_o, bus.m_int_o});
    end
    checks++;
    if (bus.m_dat_o !== 32'h0) begin
      errors++; $display("FAIL reset_m_dat: got %h required 0", bus.m_dat_o);
    end
    checks++;
    if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o} !== 13'h0) begin
      errors++; $display("FAIL reset_slave_ctrl: got %h required 0", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o});
    end
    checks++;
    if ({bus.s_adr_o, bus.s_dat_o} !== 64'h0) begin
      errors++; $display("FAIL reset_slave_data: got %h required 0", {bus.s_adr_o, bus.s_dat_o});
    end
    rst = 1'b0;
    exp_mdat = '0;
  endtask

  task automatic test_read();
    exp_t e;
    e = model(32'h02000010, 1'b0, 3, 32'hCAFEF00D, exp_mdat);
    run_xfer(32'h02000010, 1'b0, 32'h0, 4'hF, 3, 32'hCAFEF00D);
    checks++;
    if (r_ack_cycle !== e.ack_cycle || r_ack_count !== 1 || r_err_count !== 0) begin
      errors++; $display("FAIL read_ack: ack@%0d x%0d err x%0d required ack@%0d x1 err x0", r_ack_cycle, r_ack_count, r_err_count, e.ack_cycle);
    end
    checks++;
    if (r_first_stb !== e.first_stb || r_stb_count !== e.stb_count || r_bad_stb !== 0 || r_sadr !== 32'h00000010) begin
      errors++; $display("FAIL read_strobe: first %0d len %0d bad %0d adr %h required first %0d len %0d bad 0 adr 00000010",
                         r_first_stb, r_stb_count, r_bad_stb, r_sadr, e.first_stb, e.stb_count);
    end
    checks++;
    if (bus.m_dat_o !== e.dat_o) begin
      errors++; $display("FAIL read_data: got %h required %h", bus.m_dat_o, e.dat_o);
    end
    exp_mdat = e.dat_o;
  endtask

  task automatic test_write();
    exp_t e;
    e = model(32'h01000004, 1'b1, 1, 32'hDEADBEEF, exp_mdat);
    run_xfer(32'h01000004, 1'b1, 32'h12345678, 4'hF, 1, 32'hDEADBEEF);
    checks++;
    if (r_ack_cycle !== e.ack_cycle || r_ack_count !== 1 || r_err_count !== 0) begin
      errors++; $display("FAIL write_ack: ack@%0d x%0d err x%0d required ack@%0d x1 err x0", r_ack_cycle, r_ack_count, r_err_count, e.ack_cycle);
    end
    checks++;
    if (r_bad_stb !== 0 || r_unstable !== 0 || r_sdat !== 32'h12345678 || r_swe !== 1'b1 || r_ssel !== 4'hF || r_sadr !== 32'h00000004) begin
      errors++; $display("FAIL write_attrs: bad %0d unstable %0d dat %h we %b sel %h adr %h required 0 0 12345678 1 f 00000004",
                         r_bad_stb, r_unstable, r_sdat, r_swe, r_ssel, r_sadr);
    end
    checks++;
    if (bus.m_dat_o !== e.dat_o) begin
      errors++; $display("FAIL write_keeps_data: got %h required %h", bus.m_dat_o, e.dat_o);
    end
    exp_mdat = e.dat_o;
  endtask

  task automatic test_bad_address();
    exp_t e;
    e = model(32'h07000000, 1'b0, 0, 32'h11111111, exp_mdat);
    run_xfer(32'h07000000, 1'b0, 32'h0, 4'hF, 0, 32'h11111111);
    checks++;
    if (r_err_cycle !== e.err_cycle || r_err_count !== 1 || r_ack_count !== 0 || r_stb_count !== 0) begin
      errors++; $display("FAIL bad_address: err@%0d x%0d ack x%0d strobes %0d required err@%0d x1 ack x0 strobes 0",
                         r_err_cycle, r_err_count, r_ack_count, r_stb_count, e.err_cycle);
    end
    checks++;
    if (bus.m_dat_o !== e.dat_o) begin
      errors++; $display("FAIL bad_address_data: got %h required %h", bus.m_dat_o, e.dat_o);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    e = model(32'h00000100, 1'b0, 100, 32'h22222222, exp_mdat);
    run_xfer(32'h00000100, 1'b0, 32'h0, 4'h3, 100, 32'h22222222);
    checks++;
    if (r_stb_count !== TIMEOUT || r_err_cycle !== e.err_cycle || r_err_count !== 1 || r_ack_count !== 0) begin
      errors++; $display("FAIL timeout: strobes %0d err@%0d x%0d ack x%0d required strobes %0d err@%0d x1 ack x0",
                         r_stb_count, r_err_cycle, r_err_count, r_ack_count, TIMEOUT, e.err_cycle);
    end
    checks++;
    if (bus.m_dat_o !== e.dat_o) begin
      errors++; $display("FAIL timeout_data: got %h required %h", bus.m_dat_o, e.dat_o);
    end
    // ack in the very last strobe cycle must win over the timeout
    e = model(32'h03000008, 1'b0, TIMEOUT - 1, 32'h0BADF00D, exp_mdat);
    run_xfer(32'h03000008, 1'b0, 32'h0, 4'hF, TIMEOUT - 1, 32'h0BADF00D);
    checks++;
    if (r_ack_cycle !== e.ack_cycle || r_err_count !== 0 || bus.m_dat_o !== e.dat_o) begin
      errors++; $display("FAIL ack_beats_timeout: ack@%0d err x%0d dat %h required ack@%0d err x0 dat %h",
                         r_ack_cycle, r_err_count, bus.m_dat_o, e.ack_cycle, e.dat_o);
    end
    exp_mdat = e.dat_o;
  endtask

  task automatic test_random();
    exp_t        e;
    logic [31:0] adr, wdat, rdat;
    logic        we;
    logic [3:0]  sel;
    int          delay;
    for (int i = 0; i < 40; i++) begin
      adr   = {8'($urandom_range(0, 5)), 24'($urandom)};
      we    = 1'($urandom);
      wdat  = $urandom;
      rdat  = $urandom;
      sel   = 4'($urandom);
      delay = $urandom_range(0, 20);
      e = model(adr, we, delay, rdat, exp_mdat);
      run_xfer(adr, we, wdat, sel, delay, rdat);
      checks++;
      if (r_ack_cycle !== e.ack_cycle || r_err_cycle !== e.err_cycle || r_ack_count !== (e.ack_cycle >= 0 ? 1 : 0) ||
          r_err_count !== (e.err_cycle >= 0 ? 1 : 0) || r_stb_count !== e.stb_count || r_first_stb !== e.first_stb ||
          r_bad_stb !== 0) begin
        errors++; $display("FAIL random_%0d_timing: adr %h d %0d ack@%0d x%0d err@%0d x%0d stb %0d@%0d bad %0d required ack@%0d err@%0d stb %0d@%0d",
                           i, adr, delay, r_ack_cycle, r_ack_count, r_err_cycle, r_err_count, r_stb_count, r_first_stb, r_bad_stb,
                           e.ack_cycle, e.err_cycle, e.stb_count, e.first_stb);
      end
      checks++;
      if (bus.m_dat_o !== e.dat_o) begin
        errors++; $display("FAIL random_%0d_data: got %h required %h", i, bus.m_dat_o, e.dat_o);
      end
      if (e.first_stb >= 0) begin
        checks++;
        if (r_unstable !== 0 || r_sadr !== {8'h00, adr[23:0]} || r_sdat !== wdat || r_swe !== we || r_ssel !== sel) begin
          errors++; $display("FAIL random_%0d_attrs: unstable %0d adr %h dat %h we %b sel %h required 0 %h %h %b %h",
                             i, r_unstable, r_sadr, r_sdat, r_swe, r_ssel, {8'h00, adr[23:0]}, wdat, we, sel);
        end
      end
      exp_mdat = e.dat_o;
    end
  endtask

  task automatic test_abort_and_reset();
    int hits;
    @(posedge clk); #1;
    drive_req(32'h01000020, 1'b0, 32'h0, 4'hF);
    repeat (4) @(negedge clk);
    checks++;
    if (bus.s_stb_o !== 4'b0010) begin
      errors++; $display("FAIL abort_strobe: got %b required 0010", bus.s_stb_o);
    end
    bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
    hits = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.m_ack_o || bus.m_err_o || bus.s_stb_o != 0 || bus.s_cyc_o != 0) hits++;
    end
    checks++;
    if (hits !== 0) begin
      errors++; $display("FAIL abort_quiet: %0d active cycles required 0", hits);
    end
    @(posedge clk); #1;
    drive_req(32'h03000ABC, 1'b1, 32'h55AA55AA, 4'h5);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.s_stb_o !== 4'b1000) begin
      errors++; $display("FAIL reset_pre_strobe: got %b required 1000", bus.s_stb_o);
    end
    #2; rst = 1'b1; #1;
    checks++;
    if ({bus.m_dat_o, bus.m_ack_o, bus.m_err_o, bus.m_int_o, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o,
         bus.s_sel_o, bus.s_adr_o, bus.s_dat_o} !== '0) begin
      errors++; $display("FAIL reset_mid_active: stb %b adr %h dat %h mdat %h required all zero",
                         bus.s_stb_o, bus.s_adr_o, bus.s_dat_o, bus.m_dat_o);
    end
    @(negedge clk);
    bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
    rst = 1'b0;
    exp_mdat = '0;
    hits = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.m_ack_o || bus.m_err_o || bus.s_stb_o != 0) hits++;
    end
    checks++;
    if (hits !== 0) begin
      errors++; $display("FAIL reset_release_quiet: %0d active cycles required 0", hits);
    end
    // request already waiting as reset releases is taken on the first edge
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_req(32'h00000040, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    checks++;
    if (bus.s_stb_o !== 4'b0001 || bus.s_adr_o !== 32'h00000040) begin
      errors++; $display("FAIL first_edge_accept: stb %b adr %h required 0001 00000040", bus.s_stb_o, bus.s_adr_o);
    end
    bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_interrupt();
    logic [3:0] v;
    logic       prev_a, prev_b;
    prev_a = 1'b0;
    prev_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      v = (i == 0) ? 4'b1010 : 4'($urandom);
      @(negedge clk);
      bus.s_int_i = v; bus_b.s_int_i = v;
      #1;
      checks++;
      if (bus.m_int_o !== prev_a || bus_b.m_int_o !== prev_b) begin
        errors++; $display("FAIL int_latency_%0d: got %b%b required %b%b", i, bus.m_int_o, bus_b.m_int_o, prev_a, prev_b);
      end
      @(negedge clk);
      prev_a = |(v & MASK_A);
      prev_b = |(v & MASK_B);
      checks++;
      if (bus.m_int_o !== prev_a || bus_b.m_int_o !== prev_b) begin
        errors++; $display("FAIL int_mask_%0d: s_int %b got %b%b required %b%b", i, v, bus.m_int_o, bus_b.m_int_o, prev_a, prev_b);
      end
    end
    bus.s_int_i = '0; bus_b.s_int_i = '0;
  endtask

  initial begin
    rst = 1'b1;
    bus.m_we_i = 0; bus.m_cyc_i = 0; bus.m_stb_i = 0; bus.m_sel_i = '0; bus.m_adr_i = '0; bus.m_dat_i = '0;
    bus.s_ack_i = '0; bus.s_int_i = '0; bus.s_dat_i = '0;
    bus_b.m_we_i = 0; bus_b.m_cyc_i = 0; bus_b.m_stb_i = 0; bus_b.m_sel_i = '0; bus_b.m_adr_i = '0; bus_b.m_dat_i = '0;
    bus_b.s_ack_i = '0; bus_b.s_int_i = '0; bus_b.s_dat_i = '0;
    exp_mdat = '0;
    test_reset();
    test_read();
    test_write();
    test_bad_address();
    test_timeout();
    test_random();
    test_abort_and_reset();
    test_interrupt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time bound");
    $fatal(1);
  end

endmodule
